reg_dump_reader: RTL and testbench
==================================

// Module: reg_dump_reader
// PURPOSE
//  Debug/trace reader for the 32-entry register file: on a start pulse it walks
//  register addresses 0..NUM_REGS-1 through one combinational read port of the
//  register file. Each word goes out on a valid/ready stream as an (addr, data) pair.
//  Sits beside the pipelined core and drives a spare register-file read port. It
//  is the read-side counterpart of the write port used by writeback.
// PARAMETERS
//  DATA_WIDTH  32  width of a register word; must match the register file
//  NUM_REGS    32  registers dumped, from address 0; legal range 1..32
// PORTS
//  clk          in   1           clock; all state updates on posedge
//  reset        in   1           synchronous, active-high reset
//  start        in   1           request a dump; sampled only in IDLE
//  rf_rd_addr   out  5           read address driven to register file port
//  rf_rd_data   in   DATA_WIDTH  combinational read data from register file
//  dump_valid   out  1           dump_addr/dump_data/dump_last are valid
//  dump_ready   in   1           sink accepts the word when high with dump_valid
//  dump_addr    out  5           register index of current word
//  dump_data    out  DATA_WIDTH  register contents of current word
//  dump_last    out  1           current word is index NUM_REGS-1
//  busy         out  1           high in every state except IDLE
//  done         out  1           one-cycle pulse after the final word is accepted
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, cnt=0. All outputs are 0:
//    rf_rd_addr, dump_valid/addr/data/last, busy, done. Reset wins over all inputs.
//  - rf_rd_addr = cnt, a registered 5-bit counter. It is 0 in IDLE.
//  - States: IDLE -> FETCH -> SEND -> (FETCH | IDLE).
//  - IDLE: on start=1, cnt<=0, go to FETCH, busy<=1. start=0 keeps the block in IDLE.
//  - FETCH: at the posedge leaving FETCH, capture dump_data<=rf_rd_data and
//    dump_addr<=cnt. Set dump_last<=(cnt==NUM_REGS-1) and dump_valid<=1. Go to SEND.
//  - SEND: dump_valid=1. addr/data/last stay stable while dump_ready=0; there is no timeout.
//    - On dump_ready=1: dump_valid<=0.
//    - If this was the last word: done<=1 for one cycle, busy<=0, cnt<=0, go to IDLE.
//    - Otherwise: cnt<=cnt+1 and go to FETCH.
//  - Timing: start sampled at edge E0 -> dump_valid high after E1, first word is addr 0.
//    Peak throughput is one word per 2 cycles when dump_ready is held at 1.
//  - start while busy is ignored. It does not restart, queue or extend the dump.
//    start in the same cycle that done is high is also ignored; the block is still
//    leaving SEND in that cycle.
//  - Address 0 is dumped as whatever the port returns, which is 0 for x0.
//  - Coherency: the register file writes on negedge. A word reflects every write
//    completed before the FETCH posedge. There is no snapshot across the whole dump.
//  - cnt never exceeds NUM_REGS-1 and never wraps past it. NUM_REGS=32 ends at 31.
//    NUM_REGS=1 dumps only addr 0 with dump_last=1.
//  - reset mid-dump: abort immediately, no done pulse, back to IDLE with reset values.
//  - The block never drives a write; the register file write port is untouched.
// TESTING
//  1. Setup: preload xN=N*0x11 (N=1..31); start for 1 cycle; dump_ready=1 always.
//     -> 32 words, addr 0..31, data 0,0x11,..,0x20F.
//     -> dump_last only on addr 31; done 1 cycle after that accept; 64 busy cycles.
//  2. Backpressure: dump_ready=0 for 5 cycles on addr 3 (x3=0x33).
//     -> valid stays 1; addr 3 and data 0x33 stay stable; no skip or duplicate.
//  3. start pulses at word 10 and in the done cycle -> no restart; exactly one dump of 32.
//  4. Reset asserted while in SEND at addr 17.
//     -> next cycle: valid=0, busy=0, done=0, rf_rd_addr=0.
//     -> a new start dumps again from addr 0.
//  5. Concurrent write: writeback writes x5=0xDEAD_BEEF at the negedge before addr 5's FETCH.
//     -> dumped data for addr 5 is 0xDEADBEEF.
//  6. NUM_REGS=1 -> single word, addr 0, data 0, dump_last=1, done pulse; start while busy ignored.

Source files
------------

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the register file through a spare read port
// and streams every (addr, data) pair out on a valid/ready interface.
module reg_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [4:0]            rf_rd_addr,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [4:0]            dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } state_e;

  localparam logic [4:0] LAST_ADDR = 5'(NUM_REGS - 1);

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [4:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // done_q high means SEND was left on the previous edge
        if (start && !done_q) begin
          cnt_d   = 5'd0;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        data_d  = rf_rd_data;
        addr_d  = cnt_q;
        last_d  = (cnt_q == LAST_ADDR);
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (dump_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = 5'd0;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      valid_q <= 1'b0;
      addr_q  <= 5'd0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rf_rd_addr = cnt_q;
  assign dump_valid = valid_q;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;
  assign dump_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: directed and randomized dumps checked against
// a word-level model of the register file contents and stream order.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        dump_ready;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        dump_valid;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        busy;
  logic        done;

  logic        start_s;
  logic        ready_s;
  logic [4:0]  rd_addr_s;
  logic [31:0] rd_data_s;
  logic        valid_s;
  logic [4:0]  addr_s;
  logic [31:0] data_s;
  logic        last_s;
  logic        busy_s;
  logic        done_s;

  logic [31:0] rf_mem [32];
  logic [31:0] gold [32];

  int n_checks = 0;
  int n_errors = 0;

  assign rf_rd_data = rf_mem[rf_rd_addr];
  assign rd_data_s  = rf_mem[rd_addr_s];

  always #5 clk = ~clk;

  reg_dump_reader #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .busy       (busy),
    .done       (done)
  );

  reg_dump_reader #(.DATA_WIDTH(32), .NUM_REGS(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .start      (start_s),
    .rf_rd_addr (rd_addr_s),
    .rf_rd_data (rd_data_s),
    .dump_valid (valid_s),
    .dump_ready (ready_s),
    .dump_addr  (addr_s),
    .dump_data  (data_s),
    .dump_last  (last_s),
    .busy       (busy_s),
    .done       (done_s)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_valid"}, 32'(dump_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rdaddr"}, 32'(rf_rd_addr), 32'd0);
    chk({tag, "_addr"}, 32'(dump_addr), 32'd0);
    chk({tag, "_data"}, dump_data, 32'd0);
    chk({tag, "_last"}, 32'(dump_last), 32'd0);
  endtask

  // mode 0: ready always 1; 1: 5-cycle stall on addr 3; 2: random
  task automatic run_dump(input int mode, input int abort_at,
                          input bit spam, input bit do_write);
    int idx = 0;
    int cyc = 1;
    int busy_cnt = 0;
    int stalls = 0;
    int stall_left = 5;
    bit in_send = 0;
    bit done_now = 0;
    bit finished = 0;
    bit aborted = 0;
    bit pend_wr = 0;
    @(negedge clk);
    start = 1'b1;
    dump_ready = 1'b0;
    @(negedge clk);
    while (!finished && cyc < 1000) begin
      start = 1'b0;
      if (pend_wr) begin
        rf_mem[5] = 32'hDEAD_BEEF;
        gold[5] = 32'hDEAD_BEEF;
        pend_wr = 0;
      end
      if (done_now) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(dump_valid), 32'd0);
        chk("done_rdaddr", 32'(rf_rd_addr), 32'd0);
        if (spam) start = 1'b1;
        finished = 1;
      end else begin
        chk("done_low", 32'(done), 32'd0);
        chk("busy", 32'(busy), 32'd1);
        if (busy) busy_cnt++;
        chk("rd_addr", 32'(rf_rd_addr), 32'(idx));
        chk("valid", 32'(dump_valid), 32'(in_send));
        if (in_send && idx == abort_at) begin
          reset = 1'b1;
          dump_ready = 1'b0;
          aborted = 1;
          finished = 1;
        end else if (in_send) begin
          case (mode)
            0: dump_ready = 1'b1;
            1: begin
              dump_ready = !(idx == 3 && stall_left > 0);
              if (!dump_ready) stall_left--;
            end
            default: dump_ready = ($urandom_range(0, 3) != 0);
          endcase
          chk("addr", 32'(dump_addr), 32'(idx));
          chk("data", dump_data, gold[idx]);
          chk("last", 32'(dump_last), 32'(idx == 31));
          if (dump_ready) begin
            if (idx == 4 && do_write) pend_wr = 1;
            if (idx == 10 && spam) start = 1'b1;
            if (idx == 31) done_now = 1;
            else idx++;
            in_send = 0;
          end else begin
            stalls++;
          end
        end else begin
          dump_ready = $urandom_range(0, 1) == 1;
          in_send = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("finished", 32'(finished), 32'd1);
    start = 1'b0;
    if (aborted) begin
      chk_idle_zero("abort");
      reset = 1'b0;
    end else if (finished) begin
      chk("busy_cycles", 32'(busy_cnt), 32'(64 + stalls));
      for (int k = 0; k < 3; k++) begin
        chk("no_restart_busy", 32'(busy), 32'd0);
        chk("no_restart_done", 32'(done), 32'd0);
        chk("no_restart_valid", 32'(dump_valid), 32'd0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = 32'(i) * 32'h11;
      gold[i] = 32'(i) * 32'h11;
    end
    reset = 1'b1;
    start = 1'b1;
    dump_ready = 1'b1;
    start_s = 1'b1;
    ready_s = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    chk("reset_s_busy", 32'(busy_s), 32'd0);
    chk("reset_s_valid", 32'(valid_s), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    dump_ready = 1'b0;
    start_s = 1'b0;
    ready_s = 1'b0;
    @(negedge clk);
    chk_idle_zero("idle");

    run_dump(0, -1, 1'b0, 1'b0);
    run_dump(1, -1, 1'b0, 1'b1);
    run_dump(2, -1, 1'b1, 1'b0);
    run_dump(0, 17, 1'b0, 1'b0);
    run_dump(2, -1, 1'b1, 1'b0);

    @(negedge clk);
    start_s = 1'b1;
    ready_s = 1'b1;
    @(negedge clk);
    chk("s_busy", 32'(busy_s), 32'd1);
    chk("s_fetch_valid", 32'(valid_s), 32'd0);
    @(negedge clk);
    start_s = 1'b0;
    chk("s_valid", 32'(valid_s), 32'd1);
    chk("s_addr", 32'(addr_s), 32'd0);
    chk("s_data", data_s, 32'd0);
    chk("s_last", 32'(last_s), 32'd1);
    chk("s_rdaddr", 32'(rd_addr_s), 32'd0);
    @(negedge clk);
    chk("s_done", 32'(done_s), 32'd1);
    chk("s_done_busy", 32'(busy_s), 32'd0);
    chk("s_done_valid", 32'(valid_s), 32'd0);
    @(negedge clk);
    chk("s_after_done", 32'(done_s), 32'd0);
    chk("s_after_busy", 32'(busy_s), 32'd0);
    chk("s_after_valid", 32'(valid_s), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
